// File: rtl/pim_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pim_issue_ctrl
// Purpose  : EX-stage sequencer that issues PIM ops over req/gnt/rvalid and
//            stalls the pipeline until the transaction completes.
// Revision : 1.0 - initial release
// ============================================================================
module pim_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pim_valid_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        pim_req_o,
  input  logic        pim_gnt_i,
  output logic [2:0]  pim_op_o,
  output logic [31:0] pim_addr_o,
  output logic [31:0] pim_wdata_o,
  input  logic        pim_rvalid_i,
  input  logic [31:0] pim_rdata_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  localparam logic [1:0]  c_S_IDLE   = 2'd0;
  localparam logic [1:0]  c_S_REQ    = 2'd1;
  localparam logic [1:0]  c_S_WAIT   = 2'd2;
  localparam logic [1:0]  c_S_DONE   = 2'd3;
  localparam logic [2:0]  c_OP_WR    = 3'b000;
  localparam logic [2:0]  c_OP_RD    = 3'b001;
  localparam logic [2:0]  c_OP_MAC   = 3'b010;
  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [31:0] r_wb_data;
  logic        r_err;
  logic        r_wb_ok;
  logic [15:0] r_cnt;

  logic [31:0] w_ea;
  logic        w_misaligned;
  logic        w_start;
  logic        w_timeout;
  logic [2:0]  w_op_norm;
  logic        w_req;
  logic        w_stall;
  logic        w_wb_valid;
  logic        w_err;

  assign w_ea         = rs1_data_i + imm_i;
  assign w_misaligned = |w_ea[1:0];
  assign w_start      = (r_state == c_S_IDLE) && pim_valid_i && !flush_i;
  assign w_timeout    = (r_cnt == c_TMO_LAST);

  // Unknown funct3 codes are presented to the PIM unit as plain reads.
  always_comb begin
    w_op_norm = c_OP_RD;
    if ((funct3_i == c_OP_WR) || (funct3_i == c_OP_MAC)) begin
      w_op_norm = funct3_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_start) begin
          w_next_state = w_misaligned ? c_S_DONE : c_S_REQ;
        end
      end
      c_S_REQ: begin
        if (pim_gnt_i) begin
          w_next_state = (r_op == c_OP_WR) ? c_S_DONE : c_S_WAIT;
        end
      end
      c_S_WAIT: begin
        if (pim_rvalid_i || w_timeout) begin
          w_next_state = c_S_DONE;
        end
      end
      c_S_DONE: w_next_state = c_S_IDLE;
      default:  w_next_state = c_S_IDLE;
    endcase
  end

  // DONE deliberately drops stall even if pim_valid_i is still high.
  always_comb begin
    w_req      = 1'b0;
    w_stall    = 1'b0;
    w_wb_valid = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      c_S_IDLE: w_stall = pim_valid_i && !flush_i;
      c_S_REQ: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
      end
      c_S_WAIT: w_stall = 1'b1;
      c_S_DONE: begin
        w_wb_valid = r_wb_ok;
        w_err      = r_err;
      end
      default: w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_op      <= 3'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rd      <= 5'd0;
      r_wb_data <= 32'd0;
      r_err     <= 1'b0;
      r_wb_ok   <= 1'b0;
      r_cnt     <= 16'd0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_start) begin
            r_op    <= w_op_norm;
            r_addr  <= w_ea;
            r_wdata <= rs2_data_i;
            r_rd    <= rd_i;
            r_err   <= w_misaligned;
            r_wb_ok <= 1'b0;
          end
        end
        c_S_REQ: begin
          if (pim_gnt_i) begin
            r_cnt <= 16'd0;
          end
        end
        c_S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          // A response on the last allowed cycle beats the timeout.
          if (pim_rvalid_i) begin
            r_wb_data <= pim_rdata_i;
            r_wb_ok   <= 1'b1;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pim_req_o   = w_req;
  assign stall_o     = w_stall;
  assign wb_valid_o  = w_wb_valid;
  assign err_o       = w_err;
  assign pim_op_o    = r_op;
  assign pim_addr_o  = r_addr;
  assign pim_wdata_o = r_wdata;
  assign wb_rd_o     = r_rd;
  assign wb_data_o   = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_pim_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pim_issue_ctrl
// Purpose  : Self-checking bench for pim_issue_ctrl against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pim_issue_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        pim_valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        pim_req_o;
  logic        pim_gnt_i;
  logic [2:0]  pim_op_o;
  logic [31:0] pim_addr_o;
  logic [31:0] pim_wdata_o;
  logic        pim_rvalid_i;
  logic [31:0] pim_rdata_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_wb  = 32'd0;
  logic [31:0] last_ea  = 32'd0;

  always #5 clk = ~clk;

  pim_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .pim_valid_i  (pim_valid_i),
    .funct3_i     (funct3_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .imm_i        (imm_i),
    .rd_i         (rd_i),
    .flush_i      (flush_i),
    .pim_req_o    (pim_req_o),
    .pim_gnt_i    (pim_gnt_i),
    .pim_op_o     (pim_op_o),
    .pim_addr_o   (pim_addr_o),
    .pim_wdata_o  (pim_wdata_o),
    .pim_rvalid_i (pim_rvalid_i),
    .pim_rdata_i  (pim_rdata_i),
    .stall_o      (stall_o),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one instruction from its IDLE cycle through DONE; called and left at posedge+1.
  // gnt_dly: REQ cycles without grant; rv_dly: WAIT cycles without rvalid.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                        input logic [31:0] rs2, input logic [4:0] rd, input int gnt_dly,
                        input int rv_dly, input logic [31:0] rdata);
    logic [31:0] ea;
    logic [2:0]  xop;
    logic        is_wr, mis, exp_err, exp_wb, in_wait, done, bad_hold;
    logic [31:0] exp_data;
    int          exp_req, exp_wait, exp_stall;
    int          n_stall, n_req, n_w, n_err, n_wb;
    ea        = rs1 + imm;
    xop       = (f3 == 3'd0 || f3 == 3'd2) ? f3 : 3'd1;
    is_wr     = (f3 == 3'd0);
    mis       = (ea[1:0] != 2'b00);
    exp_req   = mis ? 0 : gnt_dly + 1;
    exp_wait  = (mis || is_wr) ? 0 : ((rv_dly < TMO) ? rv_dly + 1 : TMO);
    exp_stall = 1 + exp_req + exp_wait;
    exp_err   = mis || (!is_wr && rv_dly >= TMO);
    exp_wb    = !mis && !is_wr && (rv_dly < TMO);
    exp_data  = exp_wb ? rdata : last_wb;
    n_stall = 0; n_req = 0; n_w = 0; n_err = 0; n_wb = 0;
    in_wait = 1'b0; done = 1'b0; bad_hold = 1'b0;
    pim_valid_i = 1'b1; flush_i = 1'b0; funct3_i = f3;
    rs1_data_i = rs1; imm_i = imm; rs2_data_i = rs2; rd_i = rd; pim_rdata_i = rdata;
    for (int c = 0; c < 200 && !done; c++) begin
      pim_gnt_i    = pim_req_o && (n_req == gnt_dly);
      pim_rvalid_i = in_wait && (n_w == rv_dly);
      #1;
      if (stall_o) n_stall++;
      if (pim_req_o) begin
        n_req++;
        if (pim_addr_o !== ea || pim_wdata_o !== rs2 || (f3 <= 3'd2 && pim_op_o !== xop))
          bad_hold = 1'b1;
      end
      if (err_o) n_err++;
      if (wb_valid_o) n_wb++;
      if (c > 0 && !stall_o) begin
        done = 1'b1;
        check("done_err", {31'd0, err_o}, {31'd0, exp_err});
        check("done_wb_valid", {31'd0, wb_valid_o}, {31'd0, exp_wb});
        check("wb_rd", {27'd0, wb_rd_o}, {27'd0, rd});
        check("wb_data", wb_data_o, exp_data);
        check("addr_latched", pim_addr_o, ea);
        if (f3 <= 3'd2) check("op_latched", {29'd0, pim_op_o}, {29'd0, xop});
      end
      if (in_wait) n_w++;
      if (pim_req_o && pim_gnt_i && !is_wr) in_wait = 1'b1;
      @(posedge clk); #1;
    end
    pim_valid_i = 1'b0; pim_gnt_i = 1'b0; pim_rvalid_i = 1'b0;
    if (!done) check("done_bound", 32'd0, 32'd1);
    check("stall_cycles", n_stall, exp_stall);
    check("req_cycles", n_req, exp_req);
    check("err_pulses", n_err, {31'd0, exp_err});
    check("wb_pulses", n_wb, {31'd0, exp_wb});
    check("req_hold", {31'd0, bad_hold}, 32'd0);
    last_wb = exp_data;
    last_ea = ea;
  endtask

  initial begin
    logic [31:0] rs1, imm, ea;
    logic [2:0]  f3;
    rst_ni = 1'b0; pim_valid_i = 1'b0; funct3_i = 3'd0; rs1_data_i = 32'd0;
    rs2_data_i = 32'd0; imm_i = 32'd0; rd_i = 5'd0; flush_i = 1'b0;
    pim_gnt_i = 1'b0; pim_rvalid_i = 1'b0; pim_rdata_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {28'd0, pim_req_o, stall_o, wb_valid_o, err_o}, 32'd0);
    check("rst_op_rd", {24'd0, pim_op_o, wb_rd_o}, 32'd0);
    check("rst_addr", pim_addr_o, 32'd0);
    check("rst_wdata", pim_wdata_o, 32'd0);
    check("rst_wbdata", wb_data_o, 32'd0);
    rst_ni = 1'b1;

    run_op(3'd0, 32'h0000_1000, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 5'd3, 3, 0, 32'h0);
    run_op(3'd1, 32'h0000_2000, 32'h0000_0008, 32'h0, 5'd5, 0, 1, 32'h1234_5678);
    run_op(3'd1, 32'h0000_3001, 32'h0000_0000, 32'h0, 5'd6, 0, 0, 32'h0);
    run_op(3'd2, 32'h0000_5000, 32'h0000_0010, 32'h11, 5'd9, 1, 99, 32'hCAFE_0001);

    // Late response after a timeout must be ignored.
    pim_rvalid_i = 1'b1; pim_rdata_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("late_rvalid", {29'd0, wb_valid_o, err_o, stall_o}, 32'd0);
      check("late_wbdata", wb_data_o, last_wb);
      @(posedge clk); #1;
    end
    pim_rvalid_i = 1'b0;

    run_op(3'd2, 32'h0000_6000, 32'h0000_0004, 32'h22, 5'd10, 0, TMO - 1, 32'hA5A5_0F0F);
    run_op(3'd0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h3333_4444, 5'd1, 0, 0, 32'h0);
    run_op(3'd1, 32'h0000_7000, 32'h0000_0000, 32'h0, 5'd0, 2, 0, 32'h0BAD_F00D);

    // Flushed instruction must neither stall nor latch.
    pim_valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd1;
    rs1_data_i = 32'h0000_8000; imm_i = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("flush_idle", {30'd0, stall_o, pim_req_o}, 32'd0);
      @(posedge clk); #1;
    end
    check("flush_addr", pim_addr_o, last_ea);
    pim_valid_i = 1'b0; flush_i = 1'b0;

    // Reset in the middle of WAIT.
    pim_valid_i = 1'b1; funct3_i = 3'd1; rs1_data_i = 32'h0000_9000; imm_i = 32'd0;
    rs2_data_i = 32'h5555_AAAA; rd_i = 5'd7; pim_gnt_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    rst_ni = 1'b0; pim_valid_i = 1'b0; pim_gnt_i = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_outputs", {28'd0, pim_req_o, stall_o, wb_valid_o, err_o}, 32'd0);
    check("mid_rst_op_rd", {24'd0, pim_op_o, wb_rd_o}, 32'd0);
    check("mid_rst_addr", pim_addr_o, 32'd0);
    check("mid_rst_wdata", pim_wdata_o, 32'd0);
    check("mid_rst_wbdata", wb_data_o, 32'd0);
    rst_ni = 1'b1;
    last_wb = 32'd0;
    run_op(3'd1, 32'h0000_A000, 32'h0000_0004, 32'h0, 5'd12, 0, 0, 32'h7777_8888);

    for (int n = 0; n < 40; n++) begin
      f3  = 3'($urandom_range(0, 7));
      rs1 = $urandom;
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        ea  = rs1 + imm;
        imm = imm - {30'd0, ea[1:0]};
      end
      run_op(f3, rs1, imm, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), $urandom_range(0, 5), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pim_issue_ctrl.md
# pim_issue_ctrl

Execute-stage controller that sequences custom PIM instructions (`OPCODE_PIM`) onto the external PIM unit's request/grant/response interface. It forms the effective address from rs1 and the sign-extended S-format immediate, and stalls the pipeline for the whole transaction. It returns read/MAC results to writeback and reports misaligned-address and timeout errors. It sits beside the ALU in EX, fed by the decoder and the immediate generator.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum cycles spent in WAIT before the controller aborts (range 1..65535).
- `clk_i` input 1: core clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `pim_valid_i` input 1: the instruction in EX is a PIM op.
- `funct3_i` input 3: PIM op: 000 WR, 001 RD, 010 MAC. Other codes are treated as RD.
- `rs1_data_i` input 32: base address.
- `rs2_data_i` input 32: write/operand data.
- `imm_i` input 32: sign-extended S-format immediate.
- `rd_i` input 5: destination register.
- `flush_i` input 1: kill the instruction in EX.
- `pim_req_o` output 1: request to the PIM unit.
- `pim_gnt_i` input 1: grant from the PIM unit.
- `pim_op_o` output 3: latched op.
- `pim_addr_o` output 32: latched effective address.
- `pim_wdata_o` output 32: latched rs2 data.
- `pim_rvalid_i` input 1: response valid.
- `pim_rdata_i` input 32: response data.
- `stall_o` output 1: hold IF/ID/EX.
- `wb_valid_o` output 1: write `wb_data_o` to `wb_rd_o`.
- `wb_rd_o` output 5: destination register.
- `wb_data_o` output 32: result.
- `err_o` output 1: one-cycle error pulse.

## Operation
- States: IDLE, REQ, WAIT, DONE. All state transitions are registered.
- Effective address: `ea = rs1_data_i + imm_i`, modulo 2^32 (wrap-around, no carry out).
- **IDLE**
  - On `pim_valid_i && !flush_i`, latch op, ea, rs2 data and rd.
  - If `ea[1:0] != 0`, go to DONE with the error flag set; nothing is issued.
  - Otherwise go to REQ.
  - `flush_i` in IDLE suppresses the start.
- **REQ**
  - `pim_req_o = 1`. Op, address and wdata are held stable until `pim_gnt_i`.
  - The request is never withdrawn. `flush_i` is ignored from REQ onward.
  - On grant: a WR goes to DONE; RD or MAC goes to WAIT with the timeout counter cleared.
- **WAIT**
  - The counter increments every cycle.
  - On `pim_rvalid_i`, capture `pim_rdata_i` and go to DONE.
  - Otherwise, when the counter equals `TIMEOUT_CYCLES-1`, go to DONE with the error flag set.
  - `pim_rvalid_i` outside WAIT is ignored.
- **DONE**
  - Lasts one cycle, then IDLE.
  - `wb_valid_o = 1` only for a successful RD/MAC.
  - `err_o = 1` if the error flag is set.
  - `pim_valid_i` is ignored in DONE, because it still refers to the completing instruction.
- **Stall:** `stall_o = (IDLE && pim_valid_i && !flush_i) || REQ || WAIT`. It is deasserted in DONE so the pipeline advances at the end of DONE.
- **rd = x0:** `wb_valid_o` still pulses. The register file discards the write.
- **Outputs outside their valid state:**
  - `wb_data_o` holds its last captured value; it is meaningful only with `wb_valid_o`.
  - `wb_rd_o` always reflects the latched rd.

## Timing
- Reset (`rst_ni = 0` at a clock edge) forces IDLE from the next cycle, mid-transaction included. A pending request is dropped.
- Reset values:
  - Single-bit outputs: `pim_req_o`, `stall_o`, `wb_valid_o` and `err_o` are 0.
  - Data outputs: `pim_op_o`, `pim_addr_o`, `pim_wdata_o`, `wb_rd_o`, `wb_data_o` and the counter are 0.
- **WR latency** (`pim_valid_i` seen to DONE): 2 cycles plus grant wait. With grant on the first REQ cycle the sequence is IDLE→REQ→DONE, so stall is high for 2 cycles.
- **RD/MAC latency** with immediate grant and rvalid on the first WAIT cycle: IDLE→REQ→WAIT→DONE, stall high for 3 cycles. `wb_valid_o` rises in the 4th cycle.
- **Misaligned access:** IDLE→DONE, stall high for 1 cycle, `err_o` in cycle 2.
- **Timeout:** exactly `TIMEOUT_CYCLES` cycles in WAIT, then DONE with `err_o = 1` and `wb_valid_o = 0`.
- **rvalid on the final WAIT cycle:** the response wins, so no error is reported.
- **Back-to-back PIM ops:** the next op starts in the IDLE cycle following DONE. There is no bubble beyond DONE.

## Test plan
- **WR:** rs1=0x1000, imm=0xFFFFFFFC (−4), rs2=0xDEADBEEF, gnt held low 3 cycles → addr 0x00000FFC and wdata stable while req is high; req high 4 cycles; DONE with no wb and no err.
- **RD:** rs1=0x2000, imm=8, rd=5, gnt immediate, rvalid 2 cycles later with 0x12345678 → `wb_valid_o` pulse, `wb_rd_o = 5`, `wb_data_o = 0x12345678`, stall high 4 cycles.
- **Misaligned:** rs1=0x3001, imm=0 → no `pim_req_o`, `err_o` one cycle, stall 1 cycle.
- **Timeout:** `TIMEOUT_CYCLES = 4`, MAC granted, no rvalid → exactly 4 WAIT cycles, `err_o` pulse, `wb_valid_o = 0`; rvalid arriving afterwards is ignored.
- **Flush and address wrap:** `flush_i` with `pim_valid_i` in IDLE → no request, no stall. rs1=0xFFFFFFF0, imm=0x20 → addr 0x00000010.
- **Reset:** `rst_ni` low during WAIT → all outputs 0 next cycle; a new op afterwards completes normally.
